div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//  Sequencer between the execute stage and the 32-bit unsigned iterative divider.
//  Accepts DIV/DIVU, converts signed operands to magnitudes and drives the divider handshake.
//  Sign-corrects the result, owns the HI/LO registers and serves MTHI/MTLO/MFHI/MFLO.
//  Generates pipeline stall while a divide is in flight; discards results on flush.
// PARAMETERS
//  HILO_RST_VAL  32'h0  reset value of hi_o and lo_o
//  WD_CYCLES     64     watchdog: max cycles in WAIT/DRAIN without div_valid_i before err_o
// PORTS
//  clk              in   1   clock
//  reset_n          in   1   synchronous, active-low reset
//  start_i          in   1   divide request from EX, valid for one cycle
//  signed_i         in   1   1 = DIV (signed), 0 = DIVU
//  dividend_i       in   32  dividend (rs)
//  divisor_i        in   32  divisor (rt)
//  flush_i          in   1   pipeline flush; aborts the in-flight divide
//  hi_we_i          in   1   MTHI write enable
//  lo_we_i          in   1   MTLO write enable
//  wdata_i          in   32  MTHI/MTLO write data
//  mf_i             in   1   MFHI/MFLO in EX (read of hi_o/lo_o)
//  stall_o          out  1   stall EX: busy_o & (start_i | hi_we_i | lo_we_i | mf_i)
//  busy_o           out  1   state != IDLE
//  done_o           out  1   one-cycle pulse, HI/LO updated with a divide result this cycle
//  err_o            out  1   sticky watchdog error, cleared only by reset
//  hi_o             out  32  HI register (remainder)
//  lo_o             out  32  LO register (quotient)
//  div_ready_o      out  1   divider ready_i; high only in START
//  div_valid_i      in   1   divider valid_o
//  div_dividend_o   out  32  unsigned dividend magnitude, registered
//  div_divisor_o    out  32  unsigned divisor magnitude, registered
//  div_quotient_i   in   32  divider quotient, sampled only when div_valid_i
//  div_remainder_i  in   32  divider remainder, sampled only when div_valid_i
// BEHAVIOUR
//  Reset: state=IDLE; hi_o=lo_o=HILO_RST_VAL; done_o=err_o=div_ready_o=0; operand regs 0.
//  States: IDLE, START, WAIT, DRAIN.
//   IDLE : start_i & !flush_i -> latch |dividend|, |divisor|, qneg=signed&(sa^sb), rneg=signed&sa; -> START.
//          hi_we_i/lo_we_i write wdata_i to hi_o/lo_o on the same edge (only while IDLE).
//   START: div_ready_o=1 for exactly one cycle; -> WAIT (or DRAIN if flush_i).
//   WAIT : on div_valid_i: lo_o<=qneg?-q:q, hi_o<=rneg?-r:r, done_o=1 next cycle; -> IDLE.
//          flush_i (without div_valid_i) -> DRAIN. flush_i with div_valid_i: result discarded, -> IDLE.
//   DRAIN: wait for div_valid_i, discard result, no done_o; -> IDLE. Never leave the divider mid-run.
//  Operand regs held constant from acceptance until div_valid_i (divider samples them one cycle after ready).
//  div_ready_o low in WAIT so the divider returns to its idle state after its output cycle.
//  Magnitude: two's-complement negate when signed and bit31 set; 0x80000000 stays 0x80000000 unsigned.
//  Latency (31-cycle divider): accept cycle 0, START cycle 1, div_valid_i cycle 34, done_o and new HI/LO cycle 35.
//  start_i while busy: stalled via stall_o; not latched. EX holds the request until accepted.
//  start_i together with hi_we_i/lo_we_i in IDLE: both take effect; the divide result later overwrites.
//  Watchdog: counter reset on entry to WAIT/DRAIN; reaching WD_CYCLES sets err_o, forces IDLE, no HI/LO write.
//  Reset mid-operation: immediate return to reset values; divider is reset by the same reset_n.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor_i==0 at acceptance bypasses the divider (no START).
//   lo_o<=32'hFFFFFFFF, hi_o<=dividend_i (raw); done_o in cycle 1; busy_o low in cycle 1.
//  Not defined: zero divisor runs through the divider with normal timing; HI/LO value unspecified.
// TESTING
//  DIVU 100/7 -> done_o at cycle 35, lo_o=14, hi_o=2, busy_o high cycles 1..34.
//  DIV -7/2 -> lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF; DIV 7/-2 -> lo_o=32'hFFFFFFFD, hi_o=1.
//  DIV 0x80000000/0xFFFFFFFF -> lo_o=32'h80000000, hi_o=0; DIVU same operands -> lo_o=0, hi_o=32'h80000000.
//  flush_i at cycle 10, start_i at cycle 20 -> stall_o high cycles 20..34, no done_o, HI/LO unchanged;
//   second divide accepted cycle 35.
//  MTHI 0x1234 in IDLE -> hi_o=0x1234 next cycle; MFHI during busy -> stall_o=1 until IDLE.
//  DIV 5/0 with DIV_ZERO_FAST_EN -> done_o cycle 1, lo_o=32'hFFFFFFFF, hi_o=5.
//  Without DIV_ZERO_FAST_EN -> done_o cycle 35, values unchecked.
//  div_valid_i tied low -> err_o=1 at WD_CYCLES after WAIT entry, busy_o=0 next cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencer for the 32-bit iterative divider: operand magnitudes, divider handshake, sign fix-up, HI/LO ownership.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor bypasses the divider and completes in one cycle.
module div_ctrl #(
   parameter logic [31:0] HILO_RST_VAL = 32'h0,
   parameter int          WD_CYCLES    = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic        flush_i,
   input  logic        hi_we_i,
   input  logic        lo_we_i,
   input  logic [31:0] wdata_i,
   input  logic        mf_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_ready_o,
   input  logic        div_valid_i,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   input  logic [31:0] div_quotient_i,
   input  logic [31:0] div_remainder_i
);

   // state   | meaning
   // S_IDLE  | no divide in flight; MTHI/MTLO accepted, new divide may be accepted
   // S_START | div_ready_o high for one cycle, divider samples the operand regs
   // S_WAIT  | divider running; result written to HI/LO on div_valid_i
   // S_DRAIN | flushed divide still running; result discarded on div_valid_i
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

   localparam int WD_W = $clog2(WD_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WD_CYCLES - 1);

   state_t            state_q, state_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       dvd_q, dvd_d;
   logic [31:0]       dvs_q, dvs_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

   logic              a_neg, b_neg;
   logic [31:0]       a_mag, b_mag;
   logic              accept;
   logic              zero_fast;
   logic              wd_active;
   logic              wd_tc;
   logic              result_we;

   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign a_neg  = signed_i & dividend_i[31];
   assign b_neg  = signed_i & divisor_i[31];
   assign a_mag  = a_neg ? (32'd0 - dividend_i) : dividend_i;
   assign b_mag  = b_neg ? (32'd0 - divisor_i)  : divisor_i;

   assign accept    = (state_q == S_IDLE) & start_i & ~flush_i;
   assign wd_active = (state_q == S_WAIT) | (state_q == S_DRAIN);
   assign wd_tc     = (wd_cnt_q == '0);
   assign result_we = (state_q == S_WAIT) & div_valid_i & ~flush_i;

`ifdef DIV_ZERO_FAST_EN
   assign zero_fast = accept & (divisor_i == 32'd0);
`else
   assign zero_fast = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         hi_q     <= HILO_RST_VAL;
         lo_q     <= HILO_RST_VAL;
         dvd_q    <= 32'd0;
         dvs_q    <= 32'd0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         done_q   <= done_d;
         err_q    <= err_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   // Result beats watchdog beats flush; a flushed divide still drains so the divider is never cut mid-run
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && !zero_fast) state_d = S_START;
         end
         S_START: begin
            state_d = flush_i ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (div_valid_i)  state_d = S_IDLE;
            else if (wd_tc)   state_d = S_IDLE;
            else if (flush_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (div_valid_i || wd_tc) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;
      err_d    = err_q;
      wd_cnt_d = wd_cnt_q;

      if (state_q == S_IDLE) begin
         if (hi_we_i) hi_d = wdata_i;
         if (lo_we_i) lo_d = wdata_i;
      end

      if (accept && !zero_fast) begin
         dvd_d  = a_mag;
         dvs_d  = b_mag;
         qneg_d = a_neg ^ b_neg;
         rneg_d = a_neg;
      end

      if (zero_fast) begin
         lo_d   = 32'hFFFF_FFFF;
         hi_d   = dividend_i;
         done_d = 1'b1;
      end

      if (result_we) begin
         lo_d   = qneg_q ? (32'd0 - div_quotient_i)  : div_quotient_i;
         hi_d   = rneg_q ? (32'd0 - div_remainder_i) : div_remainder_i;
         done_d = 1'b1;
      end

      if (wd_active && !div_valid_i && wd_tc) err_d = 1'b1;

      if ((state_d == S_WAIT || state_d == S_DRAIN) && state_d != state_q)
         wd_cnt_d = WD_LOAD;
      else if (wd_active && !wd_tc)
         wd_cnt_d = wd_cnt_q - 1'b1;
   end

   always_comb begin
      busy_o         = (state_q != S_IDLE);
      div_ready_o    = (state_q == S_START);
      stall_o        = busy_o & (start_i | hi_we_i | lo_we_i | mf_i);
      done_o         = done_q;
      err_o          = err_q;
      hi_o           = hi_q;
      lo_o           = lo_q;
      div_dividend_o = dvd_q;
      div_divisor_o  = dvs_q;
   end

endmodule
